norm_round_stage: RTL and testbench
===================================

Name: norm_round_stage

Overview:
- Two-stage pipelined normalise-and-round unit sitting directly downstream of the FMA grand adder.
- Consumes the positive magnitude sum, result sign, pre-normalisation exponent, sticky bit and special-case flags.
- Performs leading-zero count and normalising shift, then subnormal denormalisation, IEEE-754 rounding (RISC-V modes) and packing.
- Produces the final binary floating-point result plus the RISC-V fflags through a valid/ready handshake.

Parameters:
- PARM_EXP, 8, exponent field width; BIAS = 2^(PARM_EXP-1)-1.
- PARM_MANT, 23, stored fraction width; sum width W = 3*PARM_MANT+5.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  input beat valid.
- ready_o  out  1  stage can accept input.
- PosSum_i  in  W  unsigned magnitude; value = PosSum_i * 2^(Exp_i - BIAS - (2*PARM_MANT+2)).
- Sign_i  in  1  result sign.
- Exp_i  in  PARM_EXP+2  signed two's-complement biased exponent.
- Sticky_i  in  1  nonzero bits lost below PosSum_i bit 0.
- Rm_i  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others treated as RNE.
- Nan_i  in  1  result is NaN (propagated).
- Invalid_i  in  1  invalid operation (e.g. Inf*0, Inf-Inf).
- Inf_i  in  1  result is exact infinity, sign Sign_i.
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts.
- Result_o  out  PARM_EXP+PARM_MANT+1  packed float {sign, exp, frac}.
- Fflags_o  out  5  {NV, DZ, OF, UF, NX}; DZ always 0.

Behaviour:
- Reset (async, rst_ni=0):
  - Both stage valid flags cleared; valid_o=0, Result_o=0, Fflags_o=0.
  - ready_o=1 once reset is released.
  - Reset asserted mid-operation discards in-flight beats immediately.
- Handshake (elastic, two registers):
  - s2_adv = ~s2_v | ready_i; s1_adv = ~s1_v | s2_adv; ready_o = s1_adv (combinational path from ready_i permitted).
  - Transfer in when valid_i & ready_o; transfer out when valid_o & ready_i.
  - Latency exactly 2 cycles with ready_i held 1; throughput 1 beat/cycle.
  - Order preserved. With ready_i=0 the pipe holds 2 beats and ready_o then drops.
  - Data registers load only on advance; valid_o = s2_v.
- Stage 1 (registered):
  - lzc = leading-zero count of PosSum_i; shift left by lzc so the leading one sits at bit W-1.
  - E1 = Exp_i + (W-1-lzc) - (2*PARM_MANT+2), computed signed in PARM_EXP+4 bits.
  - Register the shifted significand, E1, sign, Sticky_i, Rm_i, special flags and zero = (PosSum_i==0).
- Stage 2 (registered output):
  - Significand = top PARM_MANT+1 bits; guard = next bit; sticky = OR of the remaining bits | Sticky_i.
  - If E1<1: shift significand/guard right by 1-E1, saturated at PARM_MANT+3, with shifted-out bits ORed into sticky; exponent field 0.
  - Tiny = (E1<1), detected before rounding.
  - Round-up decision: RNE: g&(s|lsb); RTZ: 0; RDN: sign&(g|s); RUP: ~sign&(g|s); RMM: g.
  - NX = g|s.
  - Rounding carry into bit PARM_MANT+1 renormalises: shift right 1, E+1.
  - A subnormal carrying into the hidden bit becomes exponent 1 through the packing adder.
  - Overflow when final E >= 2^PARM_EXP-1: OF=1, NX=1.
    - Result is ±Inf for RNE/RMM, for RUP with +, and for RDN with -.
    - Otherwise the result is the max finite value (exp 2^PARM_EXP-2, frac all 1).
  - UF = Tiny & NX.
- Priority (highest first):
  - Invalid_i: canonical NaN {0, all-1 exp, 1 then zeros}, NV=1.
  - Nan_i: canonical NaN, no flags.
  - Inf_i: ±Inf, no flags.
  - zero & ~Sticky_i: exact zero; sign = (Rm==RDN), no flags.
  - zero & Sticky_i: magnitude below the minimum subnormal; rounds per mode to 0 or the min subnormal; UF=1, NX=1.
  - Otherwise: the normal path above.

Test Plan:
- PosSum_i=1<<48, Exp_i=127, Sign_i=0, Rm=RNE -> after 2 cycles Result_o=0x3F800000, Fflags_o=0.
- PosSum_i=(1<<48)|(1<<24), Exp_i=127:
  - RNE -> 0x3F800000, NX=1.
  - RUP -> 0x3F800001, NX=1.
  - RMM -> 0x3F800001.
- PosSum_i=1<<49, Exp_i=254:
  - RNE -> 0x7F800000, OF=1, NX=1.
  - RTZ -> 0x7F7FFFFF, OF=1, NX=1.
- PosSum_i=1<<48, Exp_i=0 -> 0x00400000, no flags.
- PosSum_i=1<<48, Exp_i=-30, Sticky_i=0, RUP -> 0x00000001, UF=1, NX=1.
- PosSum_i=0, Sticky_i=0:
  - Rm=RDN -> 0x80000000.
  - Rm=RNE -> 0x00000000.
- Invalid_i=1 -> 0x7FC00000, NV=1.
- Back-pressure: send 4 back-to-back beats with ready_i=0 for 5 cycles:
  - ready_o falls after 2 accepted beats.
  - Once ready_i=1, results emerge in order with none lost or duplicated.
- Reset pulse while 2 beats are in flight -> valid_o=0 immediately; no stale output after release.

Source files
------------

// File: rtl/norm_round_stage_if.sv
// rtl/norm_round_stage_if.sv - input/output handshake bundle for norm_round_stage
interface norm_round_stage_if #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23
);
  localparam int W = 3 * PARM_MANT + 5;

  logic                          valid_i;
  logic                          ready_o;
  logic [W-1:0]                  PosSum_i;
  logic                          Sign_i;
  logic signed [PARM_EXP+1:0]    Exp_i;
  logic                          Sticky_i;
  logic [2:0]                    Rm_i;
  logic                          Nan_i;
  logic                          Invalid_i;
  logic                          Inf_i;
  logic                          valid_o;
  logic                          ready_i;
  logic [PARM_EXP+PARM_MANT:0]   Result_o;
  logic [4:0]                    Fflags_o;

  modport slave (
    input  valid_i, PosSum_i, Sign_i, Exp_i, Sticky_i, Rm_i, Nan_i, Invalid_i, Inf_i, ready_i,
    output ready_o, valid_o, Result_o, Fflags_o
  );

  modport master (
    output valid_i, PosSum_i, Sign_i, Exp_i, Sticky_i, Rm_i, Nan_i, Invalid_i, Inf_i, ready_i,
    input  ready_o, valid_o, Result_o, Fflags_o
  );
endinterface

// File: rtl/norm_round_stage.sv
// rtl/norm_round_stage.sv - two-stage normalise/round/pack after the FMA adder
// Stage 1: LZC + normalising shift; stage 2: denormalise, round, pack, flags.
module norm_round_stage #(
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  norm_round_stage_if.slave io
);
  localparam int W   = 3 * PARM_MANT + 5;
  localparam int EW  = PARM_EXP + 4;
  localparam int SW  = PARM_MANT + 1;
  localparam int LZW = $clog2(W + 1);
  localparam int SHW = $clog2(PARM_MANT + 4);
  localparam int RW  = PARM_EXP + PARM_MANT + 1;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic signed [EW-1:0] E_ONE = EW'(1);
  localparam logic signed [EW-1:0] E_MAX = EW'((1 << PARM_EXP) - 1);
  localparam logic signed [EW-1:0] SH_SAT = EW'(PARM_MANT + 3);

  logic s1_v_q, s2_v_q, s1_adv, s2_adv;

  assign s2_adv     = ~s2_v_q | io.ready_i;
  assign s1_adv     = ~s1_v_q | s2_adv;
  assign io.ready_o = s1_adv;
  assign io.valid_o = s2_v_q;

  logic [LZW-1:0]        lzc;
  logic [W-1:0]          sig1_d, sig1_q;
  logic signed [EW-1:0]  e1_d, e1_q;
  logic [2:0]            rm1_d, rm1_q;
  logic                  sign1_q, stk1_q, nan1_q, inv1_q, inf1_q, zero1_q;

  // Ascending scan: the last hit is the most significant set bit.
  always_comb begin
    lzc = LZW'(W);
    for (int i = 0; i < W; i++) begin
      if (io.PosSum_i[i]) lzc = LZW'(W - 1 - i);
    end
  end

  assign sig1_d = io.PosSum_i << lzc;
  assign e1_d   = EW'(io.Exp_i) + EW'(W - 1 - (2 * PARM_MANT + 2)) - EW'(lzc);
  assign rm1_d  = (io.Rm_i > RM_RMM) ? RM_RNE : io.Rm_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_q  <= 1'b0;
      sig1_q  <= '0;
      e1_q    <= '0;
      rm1_q   <= '0;
      sign1_q <= 1'b0;
      stk1_q  <= 1'b0;
      nan1_q  <= 1'b0;
      inv1_q  <= 1'b0;
      inf1_q  <= 1'b0;
      zero1_q <= 1'b0;
    end else if (s1_adv) begin
      s1_v_q  <= io.valid_i;
      sig1_q  <= sig1_d;
      e1_q    <= e1_d;
      rm1_q   <= rm1_d;
      sign1_q <= io.Sign_i;
      stk1_q  <= io.Sticky_i;
      nan1_q  <= io.Nan_i;
      inv1_q  <= io.Invalid_i;
      inf1_q  <= io.Inf_i;
      zero1_q <= (io.PosSum_i == '0);
    end
  end

  logic                    tiny, sat, g, s, up, up_z, carry, ovf, ovf_inf;
  logic signed [EW-1:0]    shamt_full, e_fin;
  logic [SHW-1:0]          shamt;
  logic [SW+PARM_MANT+3:0] ext;
  logic [SW-1:0]           sig;
  logic [SW:0]             mant;
  logic [PARM_MANT-1:0]    frac;
  logic [PARM_EXP-1:0]     exp_f;
  logic [RW-1:0]           res_d, res_q;
  logic [4:0]              flg_d, flg_q;

  always_comb begin
    tiny       = e1_q[EW-1] | (e1_q == '0);
    shamt_full = E_ONE - e1_q;
    sat        = shamt_full > SH_SAT;
    shamt      = '0;
    if (tiny) shamt = sat ? SHW'(PARM_MANT + 3) : shamt_full[SHW-1:0];
    // Extra low zeros catch everything shifted out of {significand, guard}.
    ext  = {sig1_q[W-1 -: SW+1], {(PARM_MANT+3){1'b0}}} >> shamt;
    sig  = ext[SW+PARM_MANT+3 -: SW];
    g    = ext[PARM_MANT+3];
    s    = (|sig1_q[W-SW-2:0]) | stk1_q | (|ext[PARM_MANT+2:0]);
    case (rm1_q)
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = sign1_q & (g | s);
      RM_RUP:  up = ~sign1_q & (g | s);
      RM_RMM:  up = g;
      default: up = g & (s | sig[0]);
    endcase
    mant    = {1'b0, sig} + (SW+1)'(up);
    carry   = mant[SW];
    frac    = carry ? mant[PARM_MANT:1] : mant[PARM_MANT-1:0];
    e_fin   = e1_q + EW'(carry);
    // A subnormal that rounds into the hidden bit packs as exponent 1.
    exp_f   = tiny ? PARM_EXP'(mant[PARM_MANT]) : e_fin[PARM_EXP-1:0];
    ovf     = ~tiny & (e_fin >= E_MAX);
    ovf_inf = (rm1_q == RM_RNE) | (rm1_q == RM_RMM) |
              ((rm1_q == RM_RUP) & ~sign1_q) | ((rm1_q == RM_RDN) & sign1_q);
    up_z    = ((rm1_q == RM_RUP) & ~sign1_q) | ((rm1_q == RM_RDN) & sign1_q);

    res_d = {sign1_q, exp_f, frac};
    flg_d = {2'b00, 1'b0, tiny & (g | s), g | s};
    if (ovf) begin
      res_d = ovf_inf ? {sign1_q, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}}
                      : {sign1_q, {(PARM_EXP-1){1'b1}}, 1'b0, {PARM_MANT{1'b1}}};
      flg_d = 5'b00101;
    end
    if (inv1_q) begin
      res_d = {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};
      flg_d = 5'b10000;
    end else if (nan1_q) begin
      res_d = {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};
      flg_d = 5'b00000;
    end else if (inf1_q) begin
      res_d = {sign1_q, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
      flg_d = 5'b00000;
    end else if (zero1_q & ~stk1_q) begin
      res_d = {(rm1_q == RM_RDN), {(RW-1){1'b0}}};
      flg_d = 5'b00000;
    end else if (zero1_q) begin
      res_d = {sign1_q, {(RW-2){1'b0}}, up_z};
      flg_d = 5'b00011;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_v_q <= 1'b0;
      res_q  <= '0;
      flg_q  <= '0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        res_q <= res_d;
        flg_q <= flg_d;
      end
    end
  end

  assign io.Result_o = res_q;
  assign io.Fflags_o = flg_q;
endmodule

// File: tb/tb_norm_round_stage.sv
// tb/tb_norm_round_stage.sv - scoreboard bench for norm_round_stage
// Driver pushes hand-computed results; a monitor pops them on each output transfer.
module tb_norm_round_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  norm_round_stage_if #(.PARM_EXP(8), .PARM_MANT(23)) io ();
  norm_round_stage #(.PARM_EXP(8), .PARM_MANT(23)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .io    (io.slave)
  );

  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;
  localparam logic [73:0] P48  = 74'd1 << 48;
  localparam logic [73:0] P49  = 74'd1 << 49;
  localparam logic [73:0] PRND = (74'd1 << 48) | (74'd1 << 24);
  localparam logic [73:0] PALL = 74'h1FFFFFF << 24;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flg;
    logic [7:0]  id;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  int n_out  = 0;
  int vec_id = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic send(input logic [73:0] ps, input logic signed [9:0] e, input logic sg,
                      input logic st, input logic [2:0] rm, input logic nan, input logic inv,
                      input logic inf, input logic [31:0] r, input logic [4:0] f);
    int t;
    t = 0;
    @(negedge clk);
    io.PosSum_i  = ps;
    io.Exp_i     = e;
    io.Sign_i    = sg;
    io.Sticky_i  = st;
    io.Rm_i      = rm;
    io.Nan_i     = nan;
    io.Invalid_i = inv;
    io.Inf_i     = inf;
    io.valid_i   = 1'b1;
    #1;
    while (!io.ready_o && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!io.ready_o) begin
      checks++;
      $display("FAIL send_timeout vec %0d: ready_o stayed 0, required 1", vec_id);
    end else begin
      sb.push_back('{r, f, 8'(vec_id)});
    end
    vec_id++;
    @(posedge clk);
    #1;
    io.valid_i = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && io.valid_o && io.ready_i) begin
        n_out++;
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_output: got %h/%b, required no output", io.Result_o, io.Fflags_o);
        end else begin
          e = sb.pop_front();
          check($sformatf("result_v%0d", e.id), 64'(io.Result_o), 64'(e.res));
          check($sformatf("fflags_v%0d", e.id), 64'(io.Fflags_o), 64'(e.flg));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin : main
    int n0;
    io.valid_i = 1'b0; io.PosSum_i = '0; io.Exp_i = '0; io.Sign_i = 1'b0;
    io.Sticky_i = 1'b0; io.Rm_i = RNE; io.Nan_i = 1'b0; io.Invalid_i = 1'b0;
    io.Inf_i = 1'b0; io.ready_i = 1'b1;

    #12;
    check("rst_valid_o", 64'(io.valid_o), 64'd0);
    check("rst_result",  64'(io.Result_o), 64'd0);
    check("rst_fflags",  64'(io.Fflags_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready_o", 64'(io.ready_o), 64'd1);

    send(P48, 10'sd127, 0, 0, RNE, 0, 0, 0, 32'h3F800000, 5'b00000);
    check("latency_c1_valid", 64'(io.valid_o), 64'd0);
    @(posedge clk);
    #1;
    check("latency_c2_valid", 64'(io.valid_o), 64'd1);

    send(PRND, 10'sd127, 0, 0, RNE,  0, 0, 0, 32'h3F800000, 5'b00001);
    send(PRND, 10'sd127, 0, 0, RUP,  0, 0, 0, 32'h3F800001, 5'b00001);
    send(PRND, 10'sd127, 0, 0, RMM,  0, 0, 0, 32'h3F800001, 5'b00001);
    send(PRND, 10'sd127, 0, 0, 3'd6, 0, 0, 0, 32'h3F800000, 5'b00001);
    send(PRND, 10'sd127, 1, 0, RDN,  0, 0, 0, 32'hBF800001, 5'b00001);
    send(P49,  10'sd254, 0, 0, RNE,  0, 0, 0, 32'h7F800000, 5'b00101);
    send(P49,  10'sd254, 0, 0, RTZ,  0, 0, 0, 32'h7F7FFFFF, 5'b00101);
    send(P49,  10'sd254, 0, 0, RDN,  0, 0, 0, 32'h7F7FFFFF, 5'b00101);
    send(P49,  10'sd254, 1, 0, RDN,  0, 0, 0, 32'hFF800000, 5'b00101);
    send(P48,  10'sd0,   0, 0, RNE,  0, 0, 0, 32'h00400000, 5'b00000);
    send(P48,  -10'sd30, 0, 0, RUP,  0, 0, 0, 32'h00000001, 5'b00011);
    send(PALL, 10'sd127, 0, 0, RNE,  0, 0, 0, 32'h40000000, 5'b00001);
    send(PALL, 10'sd0,   0, 0, RNE,  0, 0, 0, 32'h00800000, 5'b00011);
    send('0,   10'sd0,   0, 0, RDN,  0, 0, 0, 32'h80000000, 5'b00000);
    send('0,   10'sd0,   1, 0, RNE,  0, 0, 0, 32'h00000000, 5'b00000);
    send('0,   10'sd0,   0, 1, RUP,  0, 0, 0, 32'h00000001, 5'b00011);
    send('0,   10'sd0,   0, 1, RNE,  0, 0, 0, 32'h00000000, 5'b00011);
    send(P48,  10'sd127, 0, 0, RNE,  1, 1, 0, 32'h7FC00000, 5'b10000);
    send(P48,  10'sd127, 1, 0, RNE,  1, 0, 0, 32'h7FC00000, 5'b00000);
    send(P48,  10'sd127, 1, 0, RNE,  0, 0, 1, 32'hFF800000, 5'b00000);
    drain();

    n0 = n_out;
    @(negedge clk);
    io.ready_i = 1'b0;
    send(P48,  10'sd127, 0, 0, RNE, 0, 0, 0, 32'h3F800000, 5'b00000);
    send(PRND, 10'sd127, 0, 0, RUP, 0, 0, 0, 32'h3F800001, 5'b00001);
    check("bp_ready_o_low", 64'(io.ready_o), 64'd0);
    fork
      begin
        send(P49, 10'sd254, 0, 0, RTZ, 0, 0, 0, 32'h7F7FFFFF, 5'b00101);
        send(P48, 10'sd0,   0, 0, RNE, 0, 0, 0, 32'h00400000, 5'b00000);
      end
      begin
        repeat (3) @(negedge clk);
        io.ready_i = 1'b1;
      end
    join
    drain();
    check("bp_output_count", 64'(n_out - n0), 64'd4);

    @(negedge clk);
    io.ready_i = 1'b0;
    send(PRND, 10'sd127, 0, 0, RNE, 0, 0, 0, 32'h3F800000, 5'b00001);
    send(PRND, 10'sd127, 0, 0, RMM, 0, 0, 0, 32'h3F800001, 5'b00001);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid_o", 64'(io.valid_o), 64'd0);
    sb.delete();
    n0 = n_out;
    repeat (2) @(negedge clk);
    io.ready_i = 1'b1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("postrst_valid_o", 64'(io.valid_o), 64'd0);
    check("postrst_no_output", 64'(n_out - n0), 64'd0);
    send(P48, 10'sd127, 1, 0, RNE, 0, 1, 0, 32'h7FC00000, 5'b10000);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
